alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-port round-robin arbiter and sequencer that shares the single ALU between two requesters, for example the main datapath issue port and a coprocessor/debug port. It accepts operation requests over valid/ready handshakes and drives the ALU from registered operands. It returns the registered result, zero flag and requester ID on one response channel with backpressure. It also screens the 4-bit ALU operation code and flags unsupported codes without exercising the ALU.

## Interface
Parameters:
- DATA_WIDTH, 32, width of operands and result.
- OP_WIDTH, 4, width of ALU operation code; the operation encodings below are defined for 4.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req0_valid_i  input  1  requester 0 has an operation pending.
- req0_ready_o  output  1  requester 0 request accepted this cycle.
- req0_op_i  input  OP_WIDTH  ALU operation code from requester 0.
- req0_a_i, req0_b_i  input  DATA_WIDTH  operands from requester 0.
- req1_valid_i, req1_ready_o, req1_op_i, req1_a_i, req1_b_i: same as requester 0, for requester 1.
- alu_operation_o  output  OP_WIDTH  operation code driven to the ALU.
- alu_a_o, alu_b_o  output  DATA_WIDTH  ALU operands.
- alu_result_i  input  DATA_WIDTH  combinational ALU result.
- alu_zero_i  input  1  combinational ALU zero flag.
- rsp_valid_o  output  1  response available.
- rsp_ready_i  input  1  consumer takes response.
- rsp_id_o  output  1  requester that owns the response (0/1).
- rsp_data_o  output  DATA_WIDTH  captured result.
- rsp_zero_o  output  1  captured zero flag.
- rsp_err_o  output  1  operation code was unsupported.

## Operation
- Supported codes: 0000 SUB, 0001 SRL, 0010 LUI, 0011 ADD, 0101 SLL, 0110 OR. 1001 is the idle/NOP code. All other codes are unsupported.
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - Grant logic selects at most one requester. Only the granted port's reqN_ready_o is high, combinationally, in the same cycle as its valid.
  - On grant, register op, a, b and ID, then go to EXEC.
  - With no valid request, stay in IDLE.
- Arbitration:
  - If only one requester is valid, it wins.
  - If both are valid, the requester not granted last wins.
  - last_grant resets to 1, so req0 wins the first tie.
  - last_grant updates only on a grant.
- EXEC:
  - Supported code: drive alu_operation_o/alu_a_o/alu_b_o from the registers. At the clock edge, capture alu_result_i into rsp_data and alu_zero_i into rsp_zero. Set rsp_err=0.
  - Unsupported code: keep alu_operation_o=1001 and operands 0. Capture rsp_data=0, rsp_zero=0, rsp_err=1.
  - Always go to RESP after one cycle.
- RESP:
  - rsp_valid_o=1, and all rsp_* outputs are held stable until rsp_ready_i=1.
  - On the handshake, go to IDLE.
  - reqN_ready_o=0 throughout RESP and EXEC.
- Outside EXEC: alu_operation_o=1001, alu_a_o=0, alu_b_o=0.
- Request payloads need not be held after acceptance. Withdrawing valid before acceptance is legal and has no effect.

## Timing
- Reset: state=IDLE, last_grant=1, rsp_valid_o=0, rsp_id_o=0, rsp_data_o=0, rsp_zero_o=0, rsp_err_o=0, alu_operation_o=1001, alu_a_o=0, alu_b_o=0, reqN_ready_o=0 during the reset cycle.
- Acceptance in cycle T gives ALU drive in T+1 and rsp_valid_o high in T+2.
- Minimum occupancy is 3 cycles per operation when rsp_ready_i is held high. The next grant is possible in the cycle after the response handshake.
- A response stalled by rsp_ready_i=0 holds indefinitely. A request arriving meanwhile waits, with ready low.
- reset asserted in any state aborts the operation and discards any pending response. All outputs return to reset values on the next edge.
- Both valid in the same cycle as the RESP handshake: no grant that cycle; arbitration resolves in the following IDLE cycle.

## Test plan
- Single request: req0 ADD (0011), a=5, b=7, rsp_ready high. Response at T+2 has id=0, data=12, zero=0, err=0. ALU sees 0011/5/7 in T+1 only.
- Contention: both valid continuously with distinct ops after reset. Grants alternate 0,1,0,1; four responses arrive in that ID order, each 3 cycles apart.
- Backpressure: req1 SUB a=9 b=9 with rsp_ready low for 5 cycles. rsp_valid high with data=0, zero=1 held stable; req0_ready stays 0 until the handshake, then the req0 grant follows in the next cycle.
- Unsupported code: req0 op=0111. alu_operation_o stays 1001 in EXEC; response has data=0, err=1.
- Reset mid-operation: assert reset during EXEC. Next cycle shows all outputs at reset values and no response; the first tie afterwards grants req0.
- Idle: no valid requests for 10 cycles. All ready/valid outputs stay 0, alu_operation_o=1001, and operands are 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter/sequencer sharing one ALU.
// Screens op codes; unsupported ops return err without driving the ALU.
module alu_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid_i,
    output logic                  req0_ready_o,
    input  logic [OP_WIDTH-1:0]   req0_op_i,
    input  logic [DATA_WIDTH-1:0] req0_a_i,
    input  logic [DATA_WIDTH-1:0] req0_b_i,
    input  logic                  req1_valid_i,
    output logic                  req1_ready_o,
    input  logic [OP_WIDTH-1:0]   req1_op_i,
    input  logic [DATA_WIDTH-1:0] req1_a_i,
    input  logic [DATA_WIDTH-1:0] req1_b_i,
    output logic [OP_WIDTH-1:0]   alu_operation_o,
    output logic [DATA_WIDTH-1:0] alu_a_o,
    output logic [DATA_WIDTH-1:0] alu_b_o,
    input  logic [DATA_WIDTH-1:0] alu_result_i,
    input  logic                  alu_zero_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_id_o,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  rsp_zero_o,
    output logic                  rsp_err_o
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(4'b0000);
    localparam logic [OP_WIDTH-1:0] OP_SRL = OP_WIDTH'(4'b0001);
    localparam logic [OP_WIDTH-1:0] OP_LUI = OP_WIDTH'(4'b0010);
    localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(4'b0011);
    localparam logic [OP_WIDTH-1:0] OP_SLL = OP_WIDTH'(4'b0101);
    localparam logic [OP_WIDTH-1:0] OP_OR  = OP_WIDTH'(4'b0110);
    localparam logic [OP_WIDTH-1:0] OP_NOP = OP_WIDTH'(4'b1001);

    state_t                state;
    state_t                state_next;
    logic                  last_grant;
    logic                  grant0;
    logic                  grant1;
    logic                  op_ok;
    logic [OP_WIDTH-1:0]   op_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic                  id_q;

    // Screen the registered op code against the supported set
    always_comb begin
        op_ok = (op_q == OP_SUB) || (op_q == OP_SRL) ||
                (op_q == OP_LUI) || (op_q == OP_ADD) ||
                (op_q == OP_SLL) || (op_q == OP_OR);
    end

    // Round-robin grant: on a tie the port not granted last wins
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE && !reset) begin
            if (req0_valid_i && (!req1_valid_i || last_grant)) begin
                grant0 = 1'b1;
            end else if (req1_valid_i) begin
                grant1 = 1'b1;
            end
        end
    end

    assign req0_ready_o = grant0;
    assign req1_ready_o = grant1;
    assign rsp_valid_o  = (state == RESP);

    // Next-state and ALU drive; ALU sees the NOP unless executing a legal op
    always_comb begin
        state_next      = state;
        alu_operation_o = OP_NOP;
        alu_a_o         = '0;
        alu_b_o         = '0;
        unique case (state)
            IDLE: begin
                if (grant0 || grant1) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (op_ok) begin
                    alu_operation_o = op_q;
                    alu_a_o         = a_q;
                    alu_b_o         = b_q;
                end
                state_next = RESP;
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request capture on grant and response capture at the end of EXEC
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
            op_q       <= OP_NOP;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= 1'b0;
            rsp_id_o   <= 1'b0;
            rsp_data_o <= '0;
            rsp_zero_o <= 1'b0;
            rsp_err_o  <= 1'b0;
        end else begin
            if (grant0) begin
                op_q       <= req0_op_i;
                a_q        <= req0_a_i;
                b_q        <= req0_b_i;
                id_q       <= 1'b0;
                last_grant <= 1'b0;
            end else if (grant1) begin
                op_q       <= req1_op_i;
                a_q        <= req1_a_i;
                b_q        <= req1_b_i;
                id_q       <= 1'b1;
                last_grant <= 1'b1;
            end
            if (state == EXEC) begin
                rsp_id_o <= id_q;
                if (op_ok) begin
                    rsp_data_o <= alu_result_i;
                    rsp_zero_o <= alu_zero_i;
                    rsp_err_o  <= 1'b0;
                end else begin
                    rsp_data_o <= '0;
                    rsp_zero_o <= 1'b0;
                    rsp_err_o  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid_i;
    logic        req0_ready_o;
    logic [3:0]  req0_op_i;
    logic [31:0] req0_a_i;
    logic [31:0] req0_b_i;
    logic        req1_valid_i;
    logic        req1_ready_o;
    logic [3:0]  req1_op_i;
    logic [31:0] req1_a_i;
    logic [31:0] req1_b_i;
    logic [3:0]  alu_operation_o;
    logic [31:0] alu_a_o;
    logic [31:0] alu_b_o;
    logic [31:0] alu_result_i;
    logic        alu_zero_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic        rsp_id_o;
    logic [31:0] rsp_data_o;
    logic        rsp_zero_o;
    logic        rsp_err_o;

    int checks = 0;
    int failures = 0;

    alu_arbiter #(.DATA_WIDTH(32), .OP_WIDTH(4)) dut (
        .clk(clk),
        .reset(reset),
        .req0_valid_i(req0_valid_i),
        .req0_ready_o(req0_ready_o),
        .req0_op_i(req0_op_i),
        .req0_a_i(req0_a_i),
        .req0_b_i(req0_b_i),
        .req1_valid_i(req1_valid_i),
        .req1_ready_o(req1_ready_o),
        .req1_op_i(req1_op_i),
        .req1_a_i(req1_a_i),
        .req1_b_i(req1_b_i),
        .alu_operation_o(alu_operation_o),
        .alu_a_o(alu_a_o),
        .alu_b_o(alu_b_o),
        .alu_result_i(alu_result_i),
        .alu_zero_i(alu_zero_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i),
        .rsp_id_o(rsp_id_o),
        .rsp_data_o(rsp_data_o),
        .rsp_zero_o(rsp_zero_o),
        .rsp_err_o(rsp_err_o)
    );

    always #5 clk = ~clk;

    // Behavioural ALU
    always_comb begin
        case (alu_operation_o)
            4'b0000: alu_result_i = alu_a_o - alu_b_o;
            4'b0001: alu_result_i = alu_a_o >> alu_b_o[4:0];
            4'b0010: alu_result_i = alu_b_o;
            4'b0011: alu_result_i = alu_a_o + alu_b_o;
            4'b0101: alu_result_i = alu_a_o << alu_b_o[4:0];
            4'b0110: alu_result_i = alu_a_o | alu_b_o;
            default: alu_result_i = 32'd0;
        endcase
        alu_zero_i = (alu_result_i == 32'd0);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_rvalid"}, 32'(rsp_valid_o), 32'd0);
        chk({tag, "_aluop"}, 32'(alu_operation_o), 32'h9);
        chk({tag, "_alua"}, alu_a_o, 32'd0);
        chk({tag, "_alub"}, alu_b_o, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        req0_valid_i = 1'b1;
        req0_op_i = 4'b0011;
        req0_a_i = 32'd5;
        req0_b_i = 32'd7;
        req1_valid_i = 1'b0;
        req1_op_i = 4'b0000;
        req1_a_i = 32'd0;
        req1_b_i = 32'd0;
        rsp_ready_i = 1'b1;
        tick();
        tick();
        // reset state
        chk("rst_rdy0", 32'(req0_ready_o), 32'd0);
        chk("rst_rdy1", 32'(req1_ready_o), 32'd0);
        chk_idle_outs("rst");
        chk("rst_id", 32'(rsp_id_o), 32'd0);
        chk("rst_data", rsp_data_o, 32'd0);
        chk("rst_zero", 32'(rsp_zero_o), 32'd0);
        chk("rst_err", 32'(rsp_err_o), 32'd0);

        // single ADD 5+7
        reset = 1'b0;
        #1;
        chk("add_rdy0", 32'(req0_ready_o), 32'd1);
        chk("add_rdy1", 32'(req1_ready_o), 32'd0);
        tick();
        req0_valid_i = 1'b0;
        req0_a_i = 32'hdead;
        #1;
        chk("add_exec_op", 32'(alu_operation_o), 32'h3);
        chk("add_exec_a", alu_a_o, 32'd5);
        chk("add_exec_b", alu_b_o, 32'd7);
        chk("add_exec_rv", 32'(rsp_valid_o), 32'd0);
        tick();
        chk("add_rv", 32'(rsp_valid_o), 32'd1);
        chk("add_id", 32'(rsp_id_o), 32'd0);
        chk("add_data", rsp_data_o, 32'd12);
        chk("add_zero", 32'(rsp_zero_o), 32'd0);
        chk("add_err", 32'(rsp_err_o), 32'd0);
        chk("add_resp_op", 32'(alu_operation_o), 32'h9);
        tick();
        chk_idle_outs("add_after");

        // contention after reset: grants alternate 0,1,0,1
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req0_valid_i = 1'b1;
        req0_op_i = 4'b0011;
        req0_a_i = 32'd1;
        req0_b_i = 32'd2;
        req1_valid_i = 1'b1;
        req1_op_i = 4'b0110;
        req1_a_i = 32'd4;
        req1_b_i = 32'd1;
        for (int i = 0; i < 12; i++) begin
            #1;
            chk($sformatf("cont_rdy0_%0d", i), 32'(req0_ready_o),
                32'((i % 3 == 0) && ((i / 3) % 2 == 0)));
            chk($sformatf("cont_rdy1_%0d", i), 32'(req1_ready_o),
                32'((i % 3 == 0) && ((i / 3) % 2 == 1)));
            chk($sformatf("cont_rv_%0d", i), 32'(rsp_valid_o),
                32'(i % 3 == 2));
            if (i % 3 == 2) begin
                chk($sformatf("cont_id_%0d", i), 32'(rsp_id_o),
                    32'((i / 3) % 2));
                chk($sformatf("cont_data_%0d", i), rsp_data_o,
                    ((i / 3) % 2 == 0) ? 32'd3 : 32'd5);
            end
            tick();
        end
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;

        // backpressure: req1 SUB 9-9 with rsp_ready low for 5 cycles
        req1_valid_i = 1'b1;
        req1_op_i = 4'b0000;
        req1_a_i = 32'd9;
        req1_b_i = 32'd9;
        rsp_ready_i = 1'b0;
        #1;
        chk("bp_rdy1", 32'(req1_ready_o), 32'd1);
        tick();
        req1_valid_i = 1'b0;
        req0_valid_i = 1'b1;
        req0_op_i = 4'b0011;
        req0_a_i = 32'd2;
        req0_b_i = 32'd3;
        #1;
        chk("bp_exec_rdy0", 32'(req0_ready_o), 32'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_rv_%0d", i), 32'(rsp_valid_o), 32'd1);
            chk($sformatf("bp_data_%0d", i), rsp_data_o, 32'd0);
            chk($sformatf("bp_zero_%0d", i), 32'(rsp_zero_o), 32'd1);
            chk($sformatf("bp_id_%0d", i), 32'(rsp_id_o), 32'd1);
            chk($sformatf("bp_rdy0_%0d", i), 32'(req0_ready_o), 32'd0);
            tick();
        end
        rsp_ready_i = 1'b1;
        #1;
        chk("bp_hs_rv", 32'(rsp_valid_o), 32'd1);
        chk("bp_hs_rdy0", 32'(req0_ready_o), 32'd0);
        tick();
        chk("bp_next_rv", 32'(rsp_valid_o), 32'd0);
        chk("bp_next_rdy0", 32'(req0_ready_o), 32'd1);
        tick();
        req0_valid_i = 1'b0;
        #1;
        chk("bp2_exec_op", 32'(alu_operation_o), 32'h3);
        chk("bp2_exec_a", alu_a_o, 32'd2);
        tick();
        chk("bp2_data", rsp_data_o, 32'd5);
        chk("bp2_id", 32'(rsp_id_o), 32'd0);
        tick();

        // unsupported op 0111
        req0_valid_i = 1'b1;
        req0_op_i = 4'b0111;
        req0_a_i = 32'd3;
        req0_b_i = 32'd4;
        #1;
        chk("bad_rdy0", 32'(req0_ready_o), 32'd1);
        tick();
        req0_valid_i = 1'b0;
        #1;
        chk("bad_exec_op", 32'(alu_operation_o), 32'h9);
        chk("bad_exec_a", alu_a_o, 32'd0);
        chk("bad_exec_b", alu_b_o, 32'd0);
        tick();
        chk("bad_rv", 32'(rsp_valid_o), 32'd1);
        chk("bad_data", rsp_data_o, 32'd0);
        chk("bad_zero", 32'(rsp_zero_o), 32'd0);
        chk("bad_err", 32'(rsp_err_o), 32'd1);
        tick();

        // reset during EXEC aborts the operation
        req1_valid_i = 1'b1;
        req1_op_i = 4'b0110;
        req1_a_i = 32'd1;
        req1_b_i = 32'd2;
        #1;
        chk("rmid_rdy1", 32'(req1_ready_o), 32'd1);
        tick();
        req1_valid_i = 1'b0;
        reset = 1'b1;
        #1;
        chk("rmid_exec_op", 32'(alu_operation_o), 32'h6);
        tick();
        req0_valid_i = 1'b1;
        req0_op_i = 4'b0011;
        req0_a_i = 32'd1;
        req0_b_i = 32'd2;
        req1_valid_i = 1'b1;
        #1;
        chk_idle_outs("rmid");
        chk("rmid_id", 32'(rsp_id_o), 32'd0);
        chk("rmid_err", 32'(rsp_err_o), 32'd0);
        chk("rmid_data", rsp_data_o, 32'd0);
        chk("rmid_rdy0", 32'(req0_ready_o), 32'd0);
        chk("rmid_rdy1", 32'(req1_ready_o), 32'd0);
        reset = 1'b0;
        #1;
        chk("rtie_rdy0", 32'(req0_ready_o), 32'd1);
        chk("rtie_rdy1", 32'(req1_ready_o), 32'd0);
        tick();
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        tick();
        chk("rtie_id", 32'(rsp_id_o), 32'd0);
        chk("rtie_data", rsp_data_o, 32'd3);
        tick();

        // idle for 10 cycles
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("idle_rdy0_%0d", i), 32'(req0_ready_o), 32'd0);
            chk($sformatf("idle_rdy1_%0d", i), 32'(req1_ready_o), 32'd0);
            chk_idle_outs($sformatf("idle_%0d", i));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
